// File: rtl/ex_mem_reg.sv
// Execute-to-memory pipeline register: captures ALU result and instruction context,
// squashes cmov/fault side effects, flags jump mispredicts and freezes after a halt.
module ex_mem_reg #(
    parameter int         DATA_WID = 64,
    parameter logic [3:0] RNONE    = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          e_stat,
    input  logic [3:0]          e_icode,
    input  logic [3:0]          e_ifun,
    input  logic                e_Cnd,
    input  logic [DATA_WID-1:0] e_valE,
    input  logic [DATA_WID-1:0] e_valA,
    input  logic [DATA_WID-1:0] e_valP,
    input  logic [3:0]          e_dstE,
    input  logic [3:0]          e_dstM,
    input  logic                M_stall,
    input  logic                M_bubble,
    output logic [2:0]          M_stat,
    output logic [3:0]          M_icode,
    output logic [3:0]          M_ifun,
    output logic                M_Cnd,
    output logic [DATA_WID-1:0] M_valE,
    output logic [DATA_WID-1:0] M_valA,
    output logic [3:0]          M_dstE,
    output logic [3:0]          M_dstM,
    output logic                M_mispredict,
    output logic [DATA_WID-1:0] M_redirect_pc,
    output logic                M_halted
);

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] ICODE_CMOV = 4'h2;
    localparam logic [3:0] ICODE_JXX = 4'h7;

    logic stat_ok;
    logic cmov_squash;
    logic mispredict_next;

    // Decisions made on the incoming instruction; only used on a load edge.
    always_comb begin
        stat_ok         = (e_stat == STAT_AOK);
        cmov_squash     = (e_icode == ICODE_CMOV) && !e_Cnd;
        mispredict_next = stat_ok && (e_icode == ICODE_JXX) && (e_ifun != 4'h0) && !e_Cnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_stat        <= STAT_AOK;
            M_icode       <= ICODE_NOP;
            M_ifun        <= 4'h0;
            M_Cnd         <= 1'b0;
            M_valE        <= '0;
            M_valA        <= '0;
            M_dstE        <= RNONE;
            M_dstM        <= RNONE;
            M_mispredict  <= 1'b0;
            M_redirect_pc <= '0;
            M_halted      <= 1'b0;
        end else if (M_halted) begin
            // Frozen until reset: the faulting instruction stays visible downstream.
        end else if (M_bubble) begin
            M_stat        <= STAT_AOK;
            M_icode       <= ICODE_NOP;
            M_ifun        <= 4'h0;
            M_Cnd         <= 1'b0;
            M_valE        <= '0;
            M_valA        <= '0;
            M_dstE        <= RNONE;
            M_dstM        <= RNONE;
            M_mispredict  <= 1'b0;
            M_redirect_pc <= '0;
        end else if (!M_stall) begin
            M_stat        <= e_stat;
            M_icode       <= e_icode;
            M_ifun        <= e_ifun;
            M_Cnd         <= e_Cnd;
            M_valE        <= e_valE;
            M_valA        <= e_valA;
            M_dstE        <= (!stat_ok || cmov_squash) ? RNONE : e_dstE;
            M_dstM        <= stat_ok ? e_dstM : RNONE;
            M_mispredict  <= mispredict_next;
            M_redirect_pc <= mispredict_next ? e_valP : '0;
            M_halted      <= !stat_ok;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against an instruction-level model
// of what the memory stage must see after each clock.
module tb_ex_mem_reg;

    localparam int DW = 64;

    typedef struct packed {
        logic [2:0]    stat;
        logic [3:0]    icode;
        logic [3:0]    ifun;
        logic          cnd;
        logic [DW-1:0] val_e;
        logic [DW-1:0] val_a;
        logic [3:0]    dst_e;
        logic [3:0]    dst_m;
        logic          mis;
        logic [DW-1:0] redir;
        logic          halted;
    } st_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    e_stat = 3'd1;
    logic [3:0]    e_icode = 4'h1;
    logic [3:0]    e_ifun = 4'h0;
    logic          e_Cnd = 1'b0;
    logic [DW-1:0] e_valE = '0;
    logic [DW-1:0] e_valA = '0;
    logic [DW-1:0] e_valP = '0;
    logic [3:0]    e_dstE = 4'hF;
    logic [3:0]    e_dstM = 4'hF;
    logic          M_stall = 1'b0;
    logic          M_bubble = 1'b0;

    logic [2:0]    M_stat;
    logic [3:0]    M_icode;
    logic [3:0]    M_ifun;
    logic          M_Cnd;
    logic [DW-1:0] M_valE;
    logic [DW-1:0] M_valA;
    logic [3:0]    M_dstE;
    logic [3:0]    M_dstM;
    logic          M_mispredict;
    logic [DW-1:0] M_redirect_pc;
    logic          M_halted;

    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    st_t  exp_st;

    ex_mem_reg #(.DATA_WID(DW), .RNONE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun), .e_Cnd(e_Cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP),
        .e_dstE(e_dstE), .e_dstM(e_dstM),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_mispredict(M_mispredict), .M_redirect_pc(M_redirect_pc), .M_halted(M_halted)
    );

    always #5 clk = ~clk;

    // NOP with no destinations; the halted flag is carried separately by callers.
    function automatic st_t idle_state();
        st_t s;
        s = '0;
        s.stat  = 3'd1;
        s.icode = 4'h1;
        s.dst_e = 4'hF;
        s.dst_m = 4'hF;
        return s;
    endfunction

    // What one clock does to the stage, written from the pipeline rules.
    function automatic st_t next_state(st_t cur);
        st_t n;
        bit  ok;
        if (cur.halted) return cur;
        if (M_bubble) begin
            n = idle_state();
            n.halted = cur.halted;
            return n;
        end
        if (M_stall) return cur;
        ok       = (e_stat == 3'd1);
        n.stat   = e_stat;
        n.icode  = e_icode;
        n.ifun   = e_ifun;
        n.cnd    = e_Cnd;
        n.val_e  = e_valE;
        n.val_a  = e_valA;
        n.dst_e  = (!ok || (e_icode == 4'h2 && !e_Cnd)) ? 4'hF : e_dstE;
        n.dst_m  = ok ? e_dstM : 4'hF;
        n.mis    = ok && e_icode == 4'h7 && e_ifun != 4'h0 && !e_Cnd;
        n.redir  = n.mis ? e_valP : '0;
        n.halted = !ok;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_st <= idle_state();
        else        exp_st <= next_state(exp_st);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            chk("stat",   DW'(M_stat),       DW'(exp_st.stat));
            chk("icode",  DW'(M_icode),      DW'(exp_st.icode));
            chk("ifun",   DW'(M_ifun),       DW'(exp_st.ifun));
            chk("Cnd",    DW'(M_Cnd),        DW'(exp_st.cnd));
            chk("valE",   M_valE,            exp_st.val_e);
            chk("valA",   M_valA,            exp_st.val_a);
            chk("dstE",   DW'(M_dstE),       DW'(exp_st.dst_e));
            chk("dstM",   DW'(M_dstM),       DW'(exp_st.dst_m));
            chk("mispred", DW'(M_mispredict), DW'(exp_st.mis));
            chk("redirect", M_redirect_pc,   exp_st.redir);
            chk("halted", DW'(M_halted),     DW'(exp_st.halted));
        end
    end

    // Apply one instruction and control pair, then return 1 ns after the edge.
    task automatic step(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic cnd, input logic [DW-1:0] ve, input logic [DW-1:0] va,
                        input logic [DW-1:0] vp, input logic [3:0] de, input logic [3:0] dm,
                        input logic stall, input logic bubble);
        e_stat = st; e_icode = ic; e_ifun = fn; e_Cnd = cnd;
        e_valE = ve; e_valA = va; e_valP = vp; e_dstE = de; e_dstM = dm;
        M_stall = stall; M_bubble = bubble;
        @(posedge clk);
        #1;
    endtask

    // Drop reset away from any clock edge and confirm the outputs clear at once.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_icode",  DW'(M_icode),  DW'(4'h1));
        chk("async_dstE",   DW'(M_dstE),   DW'(4'hF));
        chk("async_halted", DW'(M_halted), DW'(1'b0));
        chk("async_valE",   M_valE,        '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ic_tab [6];
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // OPq load
        step(3'd1, 4'h6, 4'h0, 1'b0, 64'h2A, 64'h7, 64'h40, 4'h3, 4'hF, 1'b0, 1'b0);
        chk("opq_valE", M_valE, 64'h2A);
        chk("opq_dstE", DW'(M_dstE), DW'(4'h3));
        chk("opq_mis",  DW'(M_mispredict), '0);

        // Stall with changing inputs holds the OPq contents
        for (int i = 0; i < 3; i++) begin
            step(3'd1, 4'h2, 4'h1, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom),
                 4'h9, 4'h8, 1'b1, 1'b0);
            chk("stall_valE", M_valE, 64'h2A);
        end
        step(3'd1, 4'h6, 4'h0, 1'b1, 64'h55, 64'h0, 64'h0, 4'h4, 4'h4, 1'b1, 1'b1);
        chk("bubble_icode", DW'(M_icode), DW'(4'h1));
        chk("bubble_dstE",  DW'(M_dstE),  DW'(4'hF));

        // cmov squash, then taken cmov
        step(3'd1, 4'h2, 4'h1, 1'b0, 64'h11, 64'h11, 64'h0, 4'h5, 4'hF, 1'b0, 1'b0);
        chk("cmov0_dstE", DW'(M_dstE), DW'(4'hF));
        step(3'd1, 4'h2, 4'h1, 1'b1, 64'h11, 64'h11, 64'h0, 4'h5, 4'hF, 1'b0, 1'b0);
        chk("cmov1_dstE", DW'(M_dstE), DW'(4'h5));

        // Conditional jump not taken mispredicts; unconditional jump never does
        step(3'd1, 4'h7, 4'h1, 1'b0, 64'h0, 64'h0, 64'h100, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("jxx_mis",   DW'(M_mispredict), DW'(1'b1));
        chk("jxx_redir", M_redirect_pc, 64'h100);
        step(3'd1, 4'h7, 4'h0, 1'b0, 64'h0, 64'h0, 64'h100, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("jmp_mis",   DW'(M_mispredict), '0);
        chk("jmp_redir", M_redirect_pc, '0);

        // Reset mid-cycle after a load
        step(3'd1, 4'h6, 4'h0, 1'b0, 64'h2A, 64'h0, 64'h0, 4'h3, 4'hF, 1'b0, 1'b0);
        reset_pulse();

        // Halt freeze
        step(3'd2, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h0, 4'h2, 4'h2, 1'b0, 1'b0);
        chk("hlt_stat",   DW'(M_stat),   DW'(3'd2));
        chk("hlt_dstE",   DW'(M_dstE),   DW'(4'hF));
        chk("hlt_halted", DW'(M_halted), DW'(1'b1));
        step(3'd1, 4'h6, 4'h0, 1'b0, 64'h99, 64'h0, 64'h0, 4'h3, 4'h3, 1'b0, 1'b0);
        step(3'd1, 4'h6, 4'h0, 1'b0, 64'h99, 64'h0, 64'h0, 4'h3, 4'h3, 1'b0, 1'b1);
        chk("frz_stat",   DW'(M_stat),   DW'(3'd2));
        chk("frz_icode",  DW'(M_icode),  DW'(4'h0));
        chk("frz_halted", DW'(M_halted), DW'(1'b1));
        reset_pulse();
        #1;
        chk("rst_halted", DW'(M_halted), '0);

        // Randomized traffic
        ic_tab[0] = 4'h2; ic_tab[1] = 4'h6; ic_tab[2] = 4'h7;
        ic_tab[3] = 4'h7; ic_tab[4] = 4'h5; ic_tab[5] = 4'h1;
        for (int i = 0; i < 600; i++) begin
            logic [2:0] st;
            logic [3:0] ic;
            if (M_halted && $urandom_range(0, 3) == 0) reset_pulse();
            st = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            ic = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ic_tab[$urandom_range(0, 5)];
            step(st, ic, 4'($urandom_range(0, 2)), 1'($urandom),
                 {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                 {32'($urandom), 32'($urandom)}, 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
Execute-to-memory pipeline register on the consuming side of the execute-stage ALU. Captures the ALU result (valE), the condition flag (Cnd) and the instruction context each cycle. Applies conditional-move squashing and branch-mispredict detection, and supports stall, bubble and a sticky halt freeze. Its outputs feed the memory stage, the forwarding logic and fetch-redirect logic.

Parameters:
DATA_WID, 64, datapath width of valE/valA/valP
RNONE, 4'hF, register ID meaning "no destination"

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
e_stat  input  3  execute-stage status (1=AOK, 2=HLT, 3=ADR, 4=INS)
e_icode  input  4  execute-stage icode
e_ifun  input  4  execute-stage ifun
e_Cnd  input  1  condition result from ALU
e_valE  input  DATA_WID  ALU result
e_valA  input  DATA_WID  operand A pass-through (store data)
e_valP  input  DATA_WID  fall-through PC of instruction
e_dstE  input  4  ALU-result destination register
e_dstM  input  4  memory-result destination register
M_stall  input  1  hold current contents
M_bubble  input  1  load NOP bubble
M_stat, M_icode, M_ifun, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  output  (same widths)  registered copies
M_mispredict  output  1  registered: taken-predicted jump was not taken
M_redirect_pc  output  DATA_WID  registered fall-through PC, valid when M_mispredict=1
M_halted  output  1  sticky: non-AOK status has been captured

Behaviour:
- Reset (rst_n=0, async, any time, including mid-stall or mid-halt) forces the following: M_stat=1, M_icode=1 (NOP), M_ifun=0, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE, M_mispredict=0, M_redirect_pc=0, M_halted=0.
- Update priority at each rising edge: halted freeze > bubble > stall > load.
- Freeze: when M_halted=1, all registers hold. Stall and bubble are ignored. Only reset clears the freeze.
- Bubble: loads reset values. M_halted is unchanged. Bubble wins over a simultaneous stall.
- Stall: all registers hold. M_mispredict also holds, so downstream logic must qualify it with its own stall.
- Load: copies all e_* inputs, 1-cycle latency, with these modifications:
  - cmov squash: if e_icode=2 and e_Cnd=0, then M_dstE=RNONE; all other fields are copied.
  - mispredict: M_mispredict = (e_icode=7 and e_ifun!=0 and e_Cnd=0). M_redirect_pc=e_valP when set, else 0. An unconditional jump (ifun=0) never mispredicts.
  - A non-AOK status squashes side effects: when e_stat!=1, M_dstE=M_dstM=RNONE and M_mispredict=0; stat, icode and vals are still captured.
  - Halt: on a load with e_stat!=1, M_halted becomes 1 from that edge onward.
- M_Cnd is registered unchanged in every case, including squashes.
- No arithmetic is performed. Widths are pass-through, with no truncation or extension.
- All outputs are driven directly from flops. No combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs immediately at reset values (M_icode=1, M_dstE=4'hF, M_halted=0) without waiting for clk.
- OPq load: e_icode=6, e_valE=64'h0000_0000_0000_002A, e_dstE=3, e_stat=1 -> next edge M_valE=0x2A, M_dstE=3, M_mispredict=0.
- cmov squash: e_icode=2, e_Cnd=0, e_dstE=5 -> M_dstE=4'hF. Repeat with e_Cnd=1 -> M_dstE=5.
- Mispredict: e_icode=7, e_ifun=1, e_Cnd=0, e_valP=0x100 -> M_mispredict=1, M_redirect_pc=0x100. Same with e_ifun=0 -> M_mispredict=0.
- Stall/bubble: load OPq, then M_stall=1 for 3 cycles with changing inputs -> outputs held. Assert M_stall and M_bubble together -> M_icode=1, M_dstE=4'hF.
- Halt freeze: e_stat=2 (HLT), e_dstE=2 -> M_stat=2, M_dstE=4'hF, M_halted=1. Later loads and bubbles -> no change. rst_n pulse -> M_halted=0.
